// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The stream is a 2-byte word count, 4 bytes per word, then one XOR checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  // Running checksum step: the image checksum is a plain XOR over the data bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bundle: load control, byte-stream handshake, RAM write port and status.
// The master side is the byte source / system; the slave side is the loader.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, we, wa, wd, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, we, wa, wd, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs stream bytes little-endian into a 32-bit word and keeps the running checksum.
// word_next is the buffer with the current byte inserted, so the 4th byte is usable at once.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last,
  output logic [7:0]  checksum
);

  logic [1:0]  idx_r;
  logic [31:0] buf_r;
  logic [7:0]  csum_r;

  // Insert the incoming byte at the current byte lane.
  always_comb begin
    word_next = buf_r;
    case (idx_r)
      2'd0:    word_next[7:0]   = byte_in;
      2'd1:    word_next[15:8]  = byte_in;
      2'd2:    word_next[23:16] = byte_in;
      2'd3:    word_next[31:24] = byte_in;
      default: word_next        = buf_r;
    endcase
  end

  assign last     = (idx_r == 2'(BYTES_PER_WORD - 1));
  assign checksum = csum_r;

  // Byte index, word buffer and checksum state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r  <= 2'd0;
      buf_r  <= 32'd0;
      csum_r <= 8'd0;
    end else if (clear) begin
      idx_r  <= 2'd0;
      buf_r  <= 32'd0;
      csum_r <= 8'd0;
    end else if (load) begin
      idx_r  <= idx_r + 2'd1;
      buf_r  <= word_next;
      csum_r <= csum_step(csum_r, byte_in);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream program image into instruction RAM while holding the CPU in reset.
// byte_ready is a pure state decode; every other output is registered.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_e             state_r;
  logic [AW-1:0]      addr_r;
  logic [CNT_W-1:0]   remaining_r;
  logic [7:0]         cnt_lo_r;
  logic               we_r;
  logic [31:0]        wa_r;
  logic [31:0]        wd_r;
  logic               cpu_hold_r;
  logic               done_r;
  logic               error_r;

  logic               byte_ready_s;
  logic               xfer_s;
  logic               start_ok_s;
  logic               pk_clear_s;
  logic               pk_load_s;
  logic [31:0]        pk_word_s;
  logic               pk_last_s;
  logic [7:0]         pk_csum_s;
  logic [CNT_W-1:0]   count_s;
  logic               count_bad_s;

  // Ready decode: the loader only takes bytes in header, data and checksum states.
  always_comb begin
    byte_ready_s = 1'b0;
    case (state_r)
      HDR_LO, HDR_HI, DATA, CHECK: byte_ready_s = 1'b1;
      default:                     byte_ready_s = 1'b0;
    endcase
  end

  // Start is honoured only when no load is in progress.
  always_comb begin
    start_ok_s = 1'b0;
    case (state_r)
      IDLE, DONE, ERR: start_ok_s = bus.start;
      default:         start_ok_s = 1'b0;
    endcase
  end

  assign xfer_s      = bus.byte_valid & byte_ready_s;
  assign pk_clear_s  = start_ok_s;
  assign pk_load_s   = xfer_s & (state_r == DATA);
  assign count_s     = CNT_W'({bus.byte_data, cnt_lo_r});
  assign count_bad_s = (count_s == {CNT_W{1'b0}}) || (count_s > CNT_W'(DEPTH));

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear_s),
    .load      (pk_load_s),
    .byte_in   (bus.byte_data),
    .word_next (pk_word_s),
    .last      (pk_last_s),
    .checksum  (pk_csum_s)
  );

  // Load sequencer with address/remaining counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      addr_r      <= {AW{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      cnt_lo_r    <= 8'd0;
      we_r        <= 1'b0;
      wa_r        <= 32'd0;
      wd_r        <= 32'd0;
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start_ok_s) begin
            state_r     <= HDR_LO;
            addr_r      <= {AW{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            cpu_hold_r  <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
          end
        end
        HDR_LO: begin
          if (xfer_s) begin
            cnt_lo_r <= bus.byte_data;
            state_r  <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (xfer_s) begin
            if (count_bad_s) begin
              state_r <= ERR;
              error_r <= 1'b1;
            end else begin
              remaining_r <= count_s;
              state_r     <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer_s && pk_last_s) begin
            state_r <= WRITE;
            we_r    <= 1'b1;
            wa_r    <= {{(32 - AW - 2){1'b0}}, addr_r, 2'b00};
            wd_r    <= pk_word_s;
          end
        end
        WRITE: begin
          remaining_r <= remaining_r - CNT_W'(1);
          // The final word does not advance addr, so it never wraps at full depth.
          if (remaining_r == CNT_W'(1)) begin
            state_r <= CHECK;
          end else begin
            addr_r  <= addr_r + AW'(1);
            state_r <= DATA;
          end
        end
        CHECK: begin
          if (xfer_s) begin
            if (bus.byte_data == pk_csum_s) begin
              state_r    <= DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_s;
  assign bus.we         = we_r;
  assign bus.wa         = wa_r;
  assign bus.wd         = wd_r;
  assign bus.cpu_hold   = cpu_hold_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte-stream program image (from a UART receiver or a testbench driver) and writes it word by word into a writable instruction RAM.
- Replaces the hard-coded file-path initial load.
- Holds the processor in reset while loading. Signals done or error when the image is finished.
- Sits between the byte source and the RAM write port. The processor read port (word address a[31:2]) is unchanged.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction RAM; the largest legal word count.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle. Transfer = byte_valid & byte_ready.
- we  out  1  RAM write strobe, one cycle per word.
- wa  out  32  RAM byte address, word aligned: {addr, 2'b00}, upper bits zero.
- wd  out  32  RAM write data.
- cpu_hold  out  1  high = keep the processor in reset.
- done  out  1  image loaded and checksum good.
- error  out  1  bad header or checksum mismatch.

Behaviour:
- Image format, in byte order:
  - count low byte, then count high byte (N = number of words).
  - 4N data bytes, each word little-endian (first byte goes to wd[7:0]).
  - one checksum byte = XOR of all 4N data bytes. The header is excluded.
- Reset (asynchronous, immediate, including mid-load):
  - state IDLE.
  - byte_ready, we, cpu_hold, done, error all 0.
  - wa 0, wd 0, internal counters and checksum 0.
  - No write strobe may survive into reset.
- IDLE:
  - byte_ready=0.
  - start -> HDR_LO; clear addr, checksum and word buffer; cpu_hold=1 from the next cycle.
- HDR_LO: byte_ready=1. On transfer, count[7:0] <= byte -> HDR_HI.
- HDR_HI: byte_ready=1. On transfer, count[15:8] <= byte, then:
  - if the full count is 0 or greater than DEPTH -> ERR.
  - otherwise -> DATA, with remaining = count.
- DATA:
  - byte_ready=1.
  - On transfer, byte k (k=0..3) goes to buffer[8k+7:8k] and checksum ^= byte.
  - After k=3 -> WRITE.
- WRITE:
  - byte_ready=0 (backpressure for exactly one cycle).
  - we=1, wa={addr,2'b00}, wd=buffer.
  - addr++, remaining--.
  - remaining becomes 0 -> CHECK; otherwise -> DATA.
- CHECK: byte_ready=1. On transfer:
  - byte == checksum -> DONE.
  - otherwise -> ERR.
- DONE: done=1, cpu_hold=0, byte_ready=0. start -> HDR_LO (reload; done clears).
- ERR: error=1, cpu_hold=1, byte_ready=0. Only start (retry) or reset leaves this state.
- Timing and handshake rules:
  - Outputs are registered, except byte_ready, which is a decode of the state.
  - we is high only in WRITE.
  - Latency from accepting the 4th byte of a word to the we cycle is 1 clock.
  - start in any loading state is ignored.
  - byte_valid while byte_ready=0 is not consumed; the source holds its byte.
  - A stalled source (byte_valid low) leaves all state frozen. There is no timeout.
  - Words already written before an error stay in RAM. error only forbids releasing cpu_hold.
- Width rules:
  - addr is clog2(DEPTH) bits and never wraps, because the count is bounded by DEPTH.
  - remaining is CNT_W bits.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHECK, DONE, ERR).
  - BYTES_PER_WORD=4.
  - header byte-count constant.
- One natural sub-module: imem_word_packer.
  - Function: 2-bit byte index, little-endian shift into a 32-bit buffer, running XOR.
  - Controls: clear and load.
- The FSM and address/remaining counters stay in imem_loader.

Test Plan:
1. Two-word load.
   - Stimulus: start; bytes 02 00 | 04 00 A0 E3 | 0C 10 90 E5 | 2E.
   - Required: we at wa=0x00 wd=0xE3A00004, then wa=0x04 wd=0xE590100C; done=1, error=0, cpu_hold=0.
2. Bad checksum.
   - Stimulus: same image, last byte 2F.
   - Required: both writes occur, then error=1, done=0, cpu_hold stays 1.
3. Illegal count.
   - Stimulus: header 41 00 (65), or 00 00.
   - Required: ERR the cycle after the second header byte; no we pulse; byte_ready=0.
4. Backpressure and gaps.
   - Stimulus: byte_valid held high continuously, plus random idle gaps.
   - Required: byte_ready=0 exactly in each WRITE cycle; no byte lost or duplicated; words identical to scenario 1.
5. Reset mid-load.
   - Stimulus: assert reset after the 3rd data byte.
   - Required: we, cpu_hold, done, error drop to 0 immediately.
   - After release, a full scenario-1 load succeeds with wa starting at 0.
6. Full-depth load and reload.
   - Stimulus: count 40 00 (64) with pattern words; then start in DONE with a one-word image.
   - Required: last write wa=0xFC; done=1.
   - The reload clears done, rewrites wa=0x00, and asserts done again.
